// File: rtl/simon_pkg.sv
// simon_pkg: shared colour type, sequence-length limit and player FSM states for the Simon game.
package simon_pkg;
  localparam int MAX_ROUNDS = 33;
  typedef logic [1:0] colour_t;
  typedef enum logic [2:0] {IDLE, SYNC, SHOW, GAP, DONE} player_state_t;
endpackage

// File: rtl/sequence_player_colour_decoder.sv
// colour_decoder: maps a 2-bit colour to its one-hot LED code.
module colour_decoder
  import simon_pkg::*;
(
  input  colour_t    colour_i,
  output logic [3:0] onehot_o
);
  assign onehot_o = 4'b0001 << colour_i;
endmodule

// File: rtl/sequence_player.sv
// sequence_player: plays a stored colour sequence on one-hot LEDs, paced by an external pulse.
// Define SEQUENCE_PLAYER_GAP_EN to blank the LEDs for one period between colours.
module sequence_player
  import simon_pkg::*;
#(
  parameter int MAX_LEN = MAX_ROUNDS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pulse,
  input  logic                 start,
  input  logic [5:0]           round_len,
  input  logic [2*MAX_LEN-1:0] segment,
  output logic [3:0]           disp_o,
  output logic                 busy,
  output logic                 done
);
  player_state_t state_q;
  logic [5:0] idx_q, len_q, idx_d, len_d, sel;
  logic [3:0] lit;
  logic last;
  assign len_d = (round_len > 6'(MAX_LEN)) ? 6'(MAX_LEN) : round_len;
  assign last = idx_q == len_q - 6'd1;
  assign idx_d = last ? idx_q : idx_q + 6'd1;
  // SYNC lights the current entry; every other lighting step lights the next one
  assign sel = (state_q == SYNC) ? idx_q : idx_d;
  colour_decoder u_dec (.colour_i(segment[{sel, 1'b0} +: 2]), .onehot_o(lit));
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      disp_o  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          len_q   <= len_d;
          idx_q   <= '0;
          busy    <= 1'b1;
          done    <= round_len == '0;
          state_q <= (round_len != '0) ? SYNC : DONE;
        end
        SYNC: if (pulse) begin
          state_q <= SHOW;
          disp_o  <= lit;
        end
        SHOW: if (pulse) begin
`ifdef SEQUENCE_PLAYER_GAP_EN
          state_q <= GAP;
          disp_o  <= '0;
`else
          state_q <= last ? DONE : SHOW;
          idx_q   <= idx_d;
          disp_o  <= last ? 4'd0 : lit;
          done    <= last;
`endif
        end
`ifdef SEQUENCE_PLAYER_GAP_EN
        GAP: if (pulse) begin
          state_q <= last ? DONE : SHOW;
          idx_q   <= idx_d;
          disp_o  <= last ? 4'd0 : lit;
          done    <= last;
        end
`endif
        DONE: begin
          state_q <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sequence_player.sv
// tb_sequence_player: directed self-checking bench for sequence_player (default or SEQUENCE_PLAYER_GAP_EN build).
module tb_sequence_player;
  logic clk = 1'b0;
  logic reset, pulse, start;
  logic [5:0] round_len;
  logic [65:0] segment;
  logic [3:0] disp_o;
  logic busy, done;
  logic [3:0] exp_q [64];
  int n_chk = 0;
  int n_pass = 0;

  sequence_player dut (
    .clk(clk), .reset(reset), .pulse(pulse), .start(start), .round_len(round_len),
    .segment(segment), .disp_o(disp_o), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_once();
    pulse = 1'b1;
    step(1);
    pulse = 1'b0;
  endtask

  task automatic go(input logic [5:0] len);
    round_len = len;
    start = 1'b1;
    pulse = 1'b1;
    step(1);
    start = 1'b0;
    pulse = 1'b0;
  endtask

  task automatic play(input int n, input int abort_at, input int restart_at);
    for (int i = 0; i < n; i++) begin
      step(4);
      if (i == restart_at) begin
        start = 1'b1;
        round_len = 6'd5;
      end
      step(1);
      start = 1'b0;
      step(4);
      if (i == 0) check("sync_dark", disp_o, 0);
      pulse_once();
      check($sformatf("show%0d", i), disp_o, exp_q[i]);
      check("busy_play", busy, 1);
      check("done_play", done, 0);
      if (i == abort_at) begin
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("abort_disp", disp_o, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        step(3);
        check("abort_nodone", done, 0);
        return;
      end
`ifdef SEQUENCE_PLAYER_GAP_EN
      step(9);
      pulse_once();
      check($sformatf("gap%0d", i), disp_o, 0);
`endif
    end
    step(9);
    pulse_once();
    check("done_hi", done, 1);
    check("done_busy", busy, 1);
    check("done_dark", disp_o, 0);
    step(1);
    check("done_lo", done, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    reset = 1'b1;
    pulse = 1'b1;
    start = 1'b1;
    round_len = 6'd3;
    segment = '0;
    step(2);
    check("rst_disp", disp_o, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    pulse = 1'b0;
    start = 1'b0;
    step(2);

    // three colours; start coincides with a pulse, which must be ignored
    segment[1:0] = 2'b00;
    segment[3:2] = 2'b11;
    segment[5:4] = 2'b01;
    exp_q[0] = 4'b0001;
    exp_q[1] = 4'b1000;
    exp_q[2] = 4'b0010;
    go(6'd3);
    check("start_busy", busy, 1);
    round_len = 6'd1;
    play(3, -1, -1);

    go(6'd0);
    check("zero_done", done, 1);
    check("zero_busy", busy, 1);
    check("zero_disp", disp_o, 0);
    step(1);
    check("zero_done_lo", done, 0);
    check("zero_idle", busy, 0);
    step(2);

    // length clamps to 33
    for (int i = 0; i < 33; i++) begin
      segment[2*i +: 2] = 2'((i * 3 + 1) % 4);
      exp_q[i] = 4'b0001 << ((i * 3 + 1) % 4);
    end
    go(6'd40);
    play(33, -1, -1);

    // restart request mid-sequence must be ignored
    segment[1:0] = 2'b10;
    segment[3:2] = 2'b01;
    exp_q[0] = 4'b0100;
    exp_q[1] = 4'b0010;
    go(6'd2);
    play(2, -1, 1);

    // reset while showing idx 2, then replay from idx 0
    segment[7:0] = 8'b00_11_10_01;
    exp_q[0] = 4'b0010;
    exp_q[1] = 4'b0100;
    exp_q[2] = 4'b1000;
    exp_q[3] = 4'b0001;
    go(6'd4);
    play(4, 2, -1);
    go(6'd4);
    play(4, -1, -1);

    // repeated colour stays lit across both periods without a gap build
    segment[3:0] = 4'b10_10;
    exp_q[0] = 4'b0100;
    exp_q[1] = 4'b0100;
    go(6'd2);
    play(2, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
